// File: rtl/blood_fx_pkg.sv
// rtl/blood_fx_pkg.sv - shared constants, state encoding and position clamp for the blood FX block
package blood_fx_pkg;

  localparam int SPRITE_SIZE = 64;
  localparam int NUM_FRAMES  = 16;
  localparam int FRAME_TICKS = 4;
  localparam int H_VISIBLE   = 640;
  localparam int V_VISIBLE   = 480;

  localparam logic [11:0] TRANSPARENT = 12'h000;

  localparam logic [9:0] X_LIMIT     = 10'(H_VISIBLE - SPRITE_SIZE);
  localparam logic [9:0] Y_LIMIT     = 10'(V_VISIBLE - SPRITE_SIZE);
  localparam logic [9:0] HALF_SPRITE = 10'(SPRITE_SIZE / 2);
  localparam logic [9:0] SPRITE_LIM  = 10'(SPRITE_SIZE);

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } fx_state_t;

  // Centre the sprite on the hit, keeping the whole 64x64 box inside the visible area.
  function automatic logic [9:0] clamp_pos(input logic [9:0] centre, input logic [9:0] limit);
    logic [9:0] v;
    v = centre - HALF_SPRITE;
    if (centre < HALF_SPRITE) return '0;
    else if (v > limit)       return limit;
    else                      return v;
  endfunction

endpackage

// File: rtl/blood_fx_if.sv
// rtl/blood_fx_if.sv - hit, video timing, ROM address/data and overlay signals of the blood FX block
interface blood_fx_if;
  logic        trigger;
  logic [9:0]  hit_x;
  logic [9:0]  hit_y;
  logic        frame_tick;
  logic        video_on;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [5:0]  rom_row;
  logic [5:0]  rom_col;
  logic [3:0]  frame_sel;
  logic [11:0] rom_data;
  logic        busy;
  logic        fx_on;
  logic [11:0] fx_rgb;

  modport slave (
    input  trigger, hit_x, hit_y, frame_tick, video_on, pixel_x, pixel_y, rom_data,
    output rom_row, rom_col, frame_sel, busy, fx_on, fx_rgb
  );

  modport master (
    output trigger, hit_x, hit_y, frame_tick, video_on, pixel_x, pixel_y, rom_data,
    input  rom_row, rom_col, frame_sel, busy, fx_on, fx_rgb
  );
endinterface

// File: rtl/blood_frame_seq.sv
// rtl/blood_frame_seq.sv - animation FSM: frame pacing, frame select and clamped hit position
module blood_frame_seq
  import blood_fx_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_trigger,
  input  logic [9:0] i_hit_x,
  input  logic [9:0] i_hit_y,
  input  logic       i_frame_tick,
  output logic       o_busy,
  output logic [3:0] o_frame_sel,
  output logic [9:0] o_pos_x,
  output logic [9:0] o_pos_y
);

  fx_state_t  r_state;
  logic [3:0] r_tick_cnt;
  logic [3:0] r_frame_sel;
  logic [9:0] r_pos_x;
  logic [9:0] r_pos_y;

  // A trigger takes priority over any frame_tick, so a hit on the final tick restarts cleanly.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_tick_cnt  <= '0;
      r_frame_sel <= '0;
      r_pos_x     <= '0;
      r_pos_y     <= '0;
    end else if (i_trigger) begin
      r_state     <= PLAY;
      r_tick_cnt  <= '0;
      r_frame_sel <= '0;
      r_pos_x     <= clamp_pos(i_hit_x, X_LIMIT);
      r_pos_y     <= clamp_pos(i_hit_y, Y_LIMIT);
    end else if (r_state == PLAY && i_frame_tick) begin
      if (r_tick_cnt < 4'(FRAME_TICKS - 1)) begin
        r_tick_cnt <= r_tick_cnt + 4'd1;
      end else begin
        r_tick_cnt <= '0;
        if (r_frame_sel == 4'(NUM_FRAMES - 1)) begin
          r_state     <= IDLE;
          r_frame_sel <= '0;
        end else begin
          r_frame_sel <= r_frame_sel + 4'd1;
        end
      end
    end
  end

  assign o_busy      = (r_state == PLAY);
  assign o_frame_sel = r_frame_sel;
  assign o_pos_x     = r_pos_x;
  assign o_pos_y     = r_pos_y;

endmodule

// File: rtl/blood_fx_ctrl.sv
// rtl/blood_fx_ctrl.sv - blood splatter sequencer top: ROM addressing, latency alignment and colour keying
module blood_fx_ctrl
  import blood_fx_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  blood_fx_if.slave  bus
);

  logic       w_busy;
  logic [3:0] w_frame_sel;
  logic [9:0] w_pos_x;
  logic [9:0] w_pos_y;
  logic [9:0] w_dx;
  logic [9:0] w_dy;
  logic       w_in_box;
  logic       w_fx_on;
  logic       r_in_box_d;
  logic       r_vid_d;

  blood_frame_seq u_seq (
    .clk          (clk),
    .reset        (reset),
    .i_trigger    (bus.trigger),
    .i_hit_x      (bus.hit_x),
    .i_hit_y      (bus.hit_y),
    .i_frame_tick (bus.frame_tick),
    .o_busy       (w_busy),
    .o_frame_sel  (w_frame_sel),
    .o_pos_x      (w_pos_x),
    .o_pos_y      (w_pos_y)
  );

  // Pixels left of/above the sprite wrap to large offsets and so fall outside the box.
  assign w_dx     = bus.pixel_x - w_pos_x;
  assign w_dy     = bus.pixel_y - w_pos_y;
  assign w_in_box = (w_dx < SPRITE_LIM) && (w_dy < SPRITE_LIM) && w_busy;

  assign bus.rom_col   = w_in_box ? w_dx[5:0] : 6'd0;
  assign bus.rom_row   = w_in_box ? w_dy[5:0] : 6'd0;
  assign bus.frame_sel = w_frame_sel;
  assign bus.busy      = w_busy;

  // The ROM registers its address, so the qualifiers are delayed to meet its data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_box_d <= 1'b0;
      r_vid_d    <= 1'b0;
    end else begin
      r_in_box_d <= w_in_box;
      r_vid_d    <= bus.video_on;
    end
  end

  assign w_fx_on    = r_in_box_d && r_vid_d && (bus.rom_data != TRANSPARENT);
  assign bus.fx_on  = w_fx_on;
  assign bus.fx_rgb = w_fx_on ? bus.rom_data : 12'h000;

endmodule

// File: tb/tb_blood_fx_ctrl.sv
// tb/tb_blood_fx_ctrl.sv - directed self-checking bench for blood_fx_ctrl
module tb_blood_fx_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  blood_fx_if bus();

  blood_fx_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fire(input logic [9:0] x, input logic [9:0] y);
    bus.trigger = 1'b1;
    bus.hit_x   = x;
    bus.hit_y   = y;
    step();
    bus.trigger = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
    end
  endtask

  task automatic addr(input string tag, input logic [9:0] px, input logic [9:0] py,
                      input logic [5:0] ecol, input logic [5:0] erow);
    bus.pixel_x = px;
    bus.pixel_y = py;
    #1;
    chk({tag, "_col"}, 12'(bus.rom_col), 12'(ecol));
    chk({tag, "_row"}, 12'(bus.rom_row), 12'(erow));
  endtask

  // Present a pixel, let the delay registers capture it, then apply ROM data.
  task automatic pix(input string tag, input logic [9:0] px, input logic [9:0] py, input logic vid,
                     input logic [11:0] data, input logic eon, input logic [11:0] ergb);
    bus.pixel_x  = px;
    bus.pixel_y  = py;
    bus.video_on = vid;
    step();
    bus.video_on = 1'b0;
    bus.rom_data = data;
    #1;
    chk({tag, "_on"}, 12'(bus.fx_on), 12'(eon));
    chk({tag, "_rgb"}, bus.fx_rgb, ergb);
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b1;
    bus.trigger    = 1'b0;
    bus.hit_x      = '0;
    bus.hit_y      = '0;
    bus.frame_tick = 1'b0;
    bus.video_on   = 1'b1;
    bus.pixel_x    = 10'd10;
    bus.pixel_y    = 10'd10;
    bus.rom_data   = 12'hE00;
    step();
    step();
    chk("rst_busy", 12'(bus.busy), 12'd0);
    chk("rst_frame", 12'(bus.frame_sel), 12'd0);
    chk("rst_fx_on", 12'(bus.fx_on), 12'd0);
    chk("rst_fx_rgb", bus.fx_rgb, 12'h000);
    chk("rst_col", 12'(bus.rom_col), 12'd0);
    chk("rst_row", 12'(bus.rom_row), 12'd0);
    reset        = 1'b0;
    bus.video_on = 1'b0;
    step();

    fire(10'd320, 10'd240);
    chk("trig_busy", 12'(bus.busy), 12'd1);
    chk("trig_frame", 12'(bus.frame_sel), 12'd0);
    addr("org", 10'd288, 10'd208, 6'd0, 6'd0);
    addr("mid", 10'd293, 10'd217, 6'd5, 6'd9);
    addr("far", 10'd351, 10'd271, 6'd63, 6'd63);
    addr("outx", 10'd352, 10'd208, 6'd0, 6'd0);
    addr("outy", 10'd300, 10'd272, 6'd0, 6'd0);

    pix("key_red", 10'd300, 10'd220, 1'b1, 12'hE00, 1'b1, 12'hE00);
    pix("key_blk", 10'd300, 10'd220, 1'b1, 12'h000, 1'b0, 12'h000);
    pix("key_vid0", 10'd300, 10'd220, 1'b0, 12'hE00, 1'b0, 12'h000);
    pix("key_out", 10'd352, 10'd208, 1'b1, 12'hE00, 1'b0, 12'h000);
    pix("key_left", 10'd287, 10'd208, 1'b1, 12'h5A3, 1'b0, 12'h000);
    pix("key_edge", 10'd351, 10'd271, 1'b1, 12'h5A3, 1'b1, 12'h5A3);

    ticks(3);
    chk("seq_t3", 12'(bus.frame_sel), 12'd0);
    ticks(1);
    chk("seq_t4", 12'(bus.frame_sel), 12'd1);
    ticks(59);
    chk("seq_t63_frame", 12'(bus.frame_sel), 12'd15);
    chk("seq_t63_busy", 12'(bus.busy), 12'd1);
    ticks(1);
    chk("seq_end_busy", 12'(bus.busy), 12'd0);
    chk("seq_end_frame", 12'(bus.frame_sel), 12'd0);
    ticks(1);
    chk("idle_tick_busy", 12'(bus.busy), 12'd0);
    chk("idle_tick_frame", 12'(bus.frame_sel), 12'd0);
    addr("idle_addr", 10'd300, 10'd220, 6'd0, 6'd0);

    fire(10'd5, 10'd470);
    addr("clampA_in", 10'd5, 10'd425, 6'd5, 6'd9);
    addr("clampA_far", 10'd63, 10'd479, 6'd63, 6'd63);
    fire(10'd639, 10'd0);
    addr("clampB_in", 10'd581, 10'd9, 6'd5, 6'd9);
    addr("clampB_far", 10'd639, 10'd63, 6'd63, 6'd63);
    pix("clampB_wrap", 10'd575, 10'd0, 1'b1, 12'hE00, 1'b0, 12'h000);

    ticks(28);
    chk("pre_retrig_frame", 12'(bus.frame_sel), 12'd7);
    fire(10'd100, 10'd100);
    chk("retrig_frame", 12'(bus.frame_sel), 12'd0);
    chk("retrig_busy", 12'(bus.busy), 12'd1);
    addr("retrig_pos", 10'd73, 10'd77, 6'd5, 6'd9);
    ticks(4);
    chk("retrig_t4", 12'(bus.frame_sel), 12'd1);

    fire(10'd320, 10'd240);
    ticks(63);
    chk("coll_pre_frame", 12'(bus.frame_sel), 12'd15);
    bus.frame_tick = 1'b1;
    fire(10'd200, 10'd150);
    bus.frame_tick = 1'b0;
    chk("coll_busy", 12'(bus.busy), 12'd1);
    chk("coll_frame", 12'(bus.frame_sel), 12'd0);
    addr("coll_pos", 10'd173, 10'd127, 6'd5, 6'd9);
    ticks(3);
    chk("coll_t3", 12'(bus.frame_sel), 12'd0);
    ticks(1);
    chk("coll_t4", 12'(bus.frame_sel), 12'd1);

    ticks(16);
    chk("pre_rst_frame", 12'(bus.frame_sel), 12'd5);
    bus.pixel_x  = 10'd180;
    bus.pixel_y  = 10'd130;
    bus.video_on = 1'b1;
    bus.rom_data = 12'hE00;
    reset        = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_busy", 12'(bus.busy), 12'd0);
    chk("mid_rst_frame", 12'(bus.frame_sel), 12'd0);
    chk("mid_rst_fx_on", 12'(bus.fx_on), 12'd0);
    pix("post_rst", 10'd180, 10'd130, 1'b1, 12'hE00, 1'b0, 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/blood_fx_ctrl.md
Name: blood_fx_ctrl

Overview:
- Sequencer and compositor for the blood-splatter animation: on a hit, it plays a 16-frame, 64x64 sprite sequence at the hit location.
- Upstream of the blood frame ROMs: it drives frame select and row/col addresses generated from the VGA pixel counters.
- Downstream of the same ROMs: it takes their 12-bit colour, applies black-as-transparent keying and produces the overlay pixel for the top-level RGB mux.

Parameters:
- SPRITE_SIZE, 64, sprite edge in pixels; fixed by the 6-bit ROM row/col.
- NUM_FRAMES, 16, animation frames, indexed 0..NUM_FRAMES-1.
- FRAME_TICKS, 4, video frames each animation frame is held (1..15).
- H_VISIBLE, 640, visible width in pixels.
- V_VISIBLE, 480, visible height in pixels.
- TRANSPARENT, 12'h000, key colour that is never drawn.

Ports:
- clk  in  1  pixel-domain clock.
- reset  in  1  synchronous, active-high reset.
- trigger  in  1  single-cycle hit pulse.
- hit_x  in  10  hit centre x, sampled on trigger.
- hit_y  in  10  hit centre y, sampled on trigger.
- frame_tick  in  1  one-cycle pulse per video frame, at start of vblank.
- video_on  in  1  visible-area flag, aligned with pixel_x/pixel_y.
- pixel_x  in  10  current pixel column.
- pixel_y  in  10  current pixel row.
- rom_row  out  6  row address to the blood ROMs.
- rom_col  out  6  column address to the blood ROMs.
- frame_sel  out  4  selects which frame ROM's data reaches rom_data.
- rom_data  in  12  selected ROM colour; valid 1 cycle after the address.
- busy  out  1  animation playing.
- fx_on  out  1  overlay pixel valid this cycle.
- fx_rgb  out  12  overlay colour; 0 when fx_on=0.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, frame_sel=0, tick_cnt=0, pos_x=pos_y=0, delay registers=0. Outputs busy=0, fx_on=0, fx_rgb=0, rom_row=rom_col=0.
- Position latch on trigger:
  - pos_x = 0 if hit_x<32; H_VISIBLE-64 (576) if hit_x-32>576; else hit_x-32.
  - pos_y is computed the same way with limit V_VISIBLE-64 (416).
- FSM state IDLE: busy=0. trigger -> latch position, frame_sel=0, tick_cnt=0, go to PLAY.
- FSM state PLAY: busy=1. On frame_tick:
  - If tick_cnt<FRAME_TICKS-1: tick_cnt++.
  - Otherwise tick_cnt=0 and either frame_sel++, or, if frame_sel==NUM_FRAMES-1, go to IDLE with frame_sel=0.
- Retrigger in PLAY: restart from frame 0 with the new position.
- trigger and the final frame_tick in the same cycle: trigger wins; result is PLAY, frame 0.
- frame_sel changes only on frame_tick (or trigger/reset), so no tearing within a displayed frame.
- Address generation (combinational):
  - dx=pixel_x-pos_x, dy=pixel_y-pos_y, both 10-bit unsigned wrap.
  - in_box = (dx<64) & (dy<64) & busy.
  - rom_col=dx[5:0], rom_row=dy[5:0] when in_box, else 0.
- ROM latency alignment: in_box and video_on are registered once (in_box_d, vid_d) to match the ROM's internal address register.
- Output:
  - fx_on = in_box_d & vid_d & (rom_data != TRANSPARENT).
  - fx_rgb = fx_on ? rom_data : 0.
  - Latency from pixel_x/pixel_y to fx_rgb is exactly 1 clk.
- Sprite edge behaviour: pos_x=576 covers columns 576..639; no wrap beyond the visible area. dx wrap for pixel_x<pos_x yields a value >=64, so the pixel is outside the box.
- Reset mid-PLAY: returns to IDLE next cycle; fx_on=0 from the following cycle.
- frame_tick while IDLE is ignored.

Decomposition:
- Package blood_fx_pkg holds:
  - SPRITE_SIZE, NUM_FRAMES, FRAME_TICKS, H_VISIBLE, V_VISIBLE, TRANSPARENT.
  - Clamp limits 576 and 416.
  - State encoding IDLE=1'b0, PLAY=1'b1.
- Sub-module blood_frame_seq owns the FSM, tick_cnt, frame_sel and position latch/clamp; it outputs busy, frame_sel, pos_x, pos_y.
- The parent blood_fx_ctrl holds address generation, the delay registers and keying.
- The 16-way ROM data mux lives outside this block.

Test Plan:
- Reset, then trigger with hit=(320,240) -> pos=(288,208), busy=1, frame_sel=0.
  - Pixel (288,208) gives rom_row=0, rom_col=0.
  - Pixel (351,271) gives row=63, col=63.
  - Pixel (352,208) gives in_box=0 and addresses 0.
- Sequencing: with FRAME_TICKS=4, apply 4 frame_ticks -> frame_sel=1.
  - After 64 ticks total: busy=0, frame_sel=0.
  - An extra frame_tick in IDLE gives no change.
- Clamp: hit=(5,470) -> pos=(0,416); hit=(639,0) -> pos=(576,0).
- Keying/latency: in_box, video_on=1.
  - rom_data=12'hE00 -> next cycle fx_on=1, fx_rgb=12'hE00.
  - rom_data=12'h000 -> fx_on=0, fx_rgb=0.
  - video_on=0 one cycle earlier -> fx_on=0.
- Collisions: retrigger at frame 7 with hit=(100,100) -> frame_sel=0, pos=(68,68).
  - trigger coincident with the final frame_tick -> busy stays 1, frame_sel=0.
- Reset asserted during frame 5 -> next cycle busy=0, frame_sel=0, fx_on=0 thereafter.
